// File: rtl/storage_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : storage_writer_pkg
//  Brief    : Shared types and constants for the storage writer and its
//             bit counter (state encoding, default commands, frame lengths).
//  Revision : 1.0 - initial release
// ============================================================================
package storage_writer_pkg;

  // FSM state encoding, 3 bits wide
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WREN = 3'd1,
    S_GAP  = 3'd2,
    S_CMD  = 3'd3,
    S_ADDR = 3'd4,
    S_DATA = 3'd5,
    S_DONE = 3'd6
  } state_e;

  // Default chip commands
  localparam logic [7:0] DEF_CMD_WREN  = 8'h06;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

  // Frame lengths in bits
  localparam int CMD_BITS  = 8;
  localparam int WORD_BITS = 16;

  // Bit counter width covers the longest frame
  localparam int CNT_W = $clog2(WORD_BITS);

endpackage : storage_writer_pkg
`default_nettype wire

// File: rtl/storage_writer_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bit_counter
//  Brief    : Free-running 4-bit counter with synchronous clear, flagging the
//             terminal counts of a command byte (7) and a word (15).
//  Revision : 1.0 - initial release
// ============================================================================
module bit_counter
  import storage_writer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  output logic o_cnt7,
  output logic o_cnt15
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear on request, otherwise count up (wrapping is harmless: callers clear on every state change)
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (i_clr) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt7  = (cnt_q == CNT_W'(CMD_BITS - 1));
  assign o_cnt15 = (cnt_q == CNT_W'(WORD_BITS - 1));

endmodule : bit_counter
`default_nettype wire

// File: rtl/storage_writer.sv
`default_nettype none
// ============================================================================
//  Module   : storage_writer
//  Brief    : Streams a word-addressed memory range to the serial storage
//             chip as WREN, then one write frame (command, 16-bit address,
//             big-endian words), then pulses done.
//  Revision : 1.0 - initial release
// ============================================================================
module storage_writer
  import storage_writer_pkg::*;
#(
  parameter logic [7:0] CMD_WREN  = DEF_CMD_WREN,
  parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
  parameter bit         USE_WREN  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [15:0] i_memFirst,
  input  logic [15:0] i_memLast,
  input  logic [15:0] i_storeAddr,
  output logic [15:0] o_memAddr,
  input  logic [15:0] i_memData,
  output logic        o_memEn,
  output logic        o_storeEn,
  output logic        o_storeSDI,
  output logic        o_busy,
  output logic        o_done
);

  localparam int PAD_BITS = WORD_BITS - CMD_BITS;

  state_e      state_q,   state_d;
  logic [15:0] shift_q,   shift_d;
  logic [15:0] addr_q,    addr_d;
  logic [15:0] last_q,    last_d;
  logic [15:0] store_q,   store_d;
  logic        islast_q,  islast_d;
  logic        mem_en;
  logic        cnt7;
  logic        cnt15;

  // Counter restarts at every state transition so each frame field counts from 0
  bit_counter u_bit_counter (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clr   (state_d != state_q),
    .o_cnt7  (cnt7),
    .o_cnt15 (cnt15)
  );

  // Next-state, shift-register and address-counter logic
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    last_d   = last_q;
    store_d  = store_q;
    islast_d = islast_q;
    mem_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = i_memFirst;
          last_d  = i_memLast;
          store_d = i_storeAddr;
          if (USE_WREN) begin
            state_d = S_WREN;
            shift_d = {CMD_WREN, {PAD_BITS{1'b0}}};
          end else begin
            state_d = S_CMD;
            shift_d = {CMD_WRITE, {PAD_BITS{1'b0}}};
          end
        end
      end

      S_WREN: begin
        shift_d = {shift_q[14:0], 1'b0};
        if (cnt7) begin
          state_d = S_GAP;
        end
      end

      // Chip select low for one cycle so the chip commits the WREN
      S_GAP: begin
        state_d = S_CMD;
        shift_d = {CMD_WRITE, {PAD_BITS{1'b0}}};
      end

      S_CMD: begin
        shift_d = {shift_q[14:0], 1'b0};
        if (cnt7) begin
          state_d = S_ADDR;
          shift_d = store_q;
        end
      end

      // Last address bit: fetch the first word so it follows without a gap
      S_ADDR: begin
        shift_d = {shift_q[14:0], 1'b0};
        if (cnt15) begin
          state_d  = S_DATA;
          mem_en   = 1'b1;
          shift_d  = i_memData;
          addr_d   = addr_q + 16'd1;
          islast_d = (addr_q == last_q);
        end
      end

      // End of each word: either finish or prefetch the next one.
      // Termination is by equality so ranges may wrap through 0xFFFF.
      S_DATA: begin
        shift_d = {shift_q[14:0], 1'b0};
        if (cnt15) begin
          if (islast_q) begin
            state_d = S_DONE;
          end else begin
            mem_en   = 1'b1;
            shift_d  = i_memData;
            addr_d   = addr_q + 16'd1;
            islast_d = (addr_q == last_q);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      addr_q   <= '0;
      last_q   <= '0;
      store_q  <= '0;
      islast_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      store_q  <= store_d;
      islast_q <= islast_d;
    end
  end

  assign o_storeEn  = (state_q == S_WREN) || (state_q == S_CMD) ||
                      (state_q == S_ADDR) || (state_q == S_DATA);
  assign o_storeSDI = o_storeEn & shift_q[15];
  assign o_memEn    = mem_en;
  // Address bus is driven only while reading so the shared bus stays released
  assign o_memAddr  = mem_en ? addr_q : 16'h0000;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);

endmodule : storage_writer
`default_nettype wire

// File: tb/tb_storage_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_storage_writer
//  Brief    : Self-checking bench for storage_writer; one instance with the
//             WREN preamble and one without, checked cycle by cycle against
//             an expected bit stream built from the frame description.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_storage_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start1, start0;
  logic [15:0] first, last, saddr;
  logic [15:0] mem [0:65535];

  logic [15:0] addr1, data1, addr0, data0;
  logic        men1, sen1, sdi1, busy1, done1;
  logic        men0, sen0, sdi0, busy0, done0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign data1 = mem[addr1];
  assign data0 = mem[addr0];

  storage_writer #(.USE_WREN(1'b1)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start1),
    .i_memFirst(first), .i_memLast(last), .i_storeAddr(saddr),
    .o_memAddr(addr1), .i_memData(data1), .o_memEn(men1),
    .o_storeEn(sen1), .o_storeSDI(sdi1), .o_busy(busy1), .o_done(done1)
  );

  storage_writer #(.USE_WREN(1'b0)) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start0),
    .i_memFirst(first), .i_memLast(last), .i_storeAddr(saddr),
    .o_memAddr(addr0), .i_memData(data0), .o_memEn(men0),
    .o_storeEn(sen0), .o_storeSDI(sdi0), .o_busy(busy0), .o_done(done0)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] observe(input bit w);
    return w ? {sen1, sdi1, men1, busy1, done1} : {sen0, sdi0, men0, busy0, done0};
  endfunction

  // Builds the expected serial frame from the range description, then runs
  // the operation and compares every cycle. Optional: stray starts at T+20
  // and in the done cycle, and a reset asserted during cycle T+rst_at.
  task automatic run_op(input bit w, input logic [15:0] f, input logic [15:0] l,
                        input logic [15:0] s, input bit stray, input int rst_at,
                        input string name);
    bit          qen[$];
    bit          qsdi[$];
    int          rdj[$];
    logic [15:0] rda[$];
    logic [15:0] a, d;
    logic [7:0]  c;
    logic [4:0]  exp;
    logic [15:0] exp_addr;
    int          done_j, last_j;
    bit          rd;

    if (w) begin
      c = 8'h06;
      for (int i = 7; i >= 0; i--) begin qen.push_back(1'b1); qsdi.push_back(c[i]); end
      qen.push_back(1'b0); qsdi.push_back(1'b0);
    end
    c = 8'h02;
    for (int i = 7; i >= 0; i--) begin qen.push_back(1'b1); qsdi.push_back(c[i]); end
    for (int i = 15; i >= 0; i--) begin qen.push_back(1'b1); qsdi.push_back(s[i]); end
    a = f;
    for (int k = 0; k < 8; k++) begin
      // word read happens in the cycle just before its first bit
      rdj.push_back(qen.size());
      rda.push_back(a);
      d = mem[a];
      for (int i = 15; i >= 0; i--) begin qen.push_back(1'b1); qsdi.push_back(d[i]); end
      if (a == l) break;
      a = a + 16'd1;
    end
    done_j = qen.size() + 1;
    last_j = (rst_at > 0) ? rst_at + 3 : done_j + 2;

    first = f; last = l; saddr = s;
    @(negedge clk);
    if (w) start1 = 1'b1; else start0 = 1'b1;

    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk);
      start1 = 1'b0; start0 = 1'b0;
      if (j == 1) begin
        // inputs after acceptance must not affect the frame
        first = 16'($urandom); last = 16'($urandom); saddr = 16'($urandom);
      end
      rd = 1'b0;
      exp_addr = 16'h0000;
      for (int r = 0; r < rdj.size(); r++) begin
        if (rdj[r] == j) begin rd = 1'b1; exp_addr = rda[r]; end
      end
      if (rst_at > 0 && j > rst_at) begin
        exp = 5'b0;
        rd  = 1'b0;
      end else begin
        exp[4] = (j <= qen.size()) ? qen[j-1]  : 1'b0;
        exp[3] = (j <= qen.size()) ? qsdi[j-1] : 1'b0;
        exp[2] = rd;
        exp[1] = (j <= done_j);
        exp[0] = (j == done_j);
      end
      check($sformatf("%s T+%0d en/sdi/memEn/busy/done", name, j), {11'b0, observe(w)}, {11'b0, exp});
      if (rd) check($sformatf("%s T+%0d memAddr", name, j), w ? addr1 : addr0, exp_addr);
      if (stray && (j == 20 || j == done_j)) begin
        if (w) start1 = 1'b1; else start0 = 1'b1;
      end
      if (rst_at > 0 && j == rst_at)     rstn = 1'b0;
      if (rst_at > 0 && j == rst_at + 1) rstn = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] rf, rs;
    int          rn;
    bit          rw;

    rstn = 1'b0; start1 = 1'b0; start0 = 1'b0;
    first = 16'h0; last = 16'h0; saddr = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'hBEEF;
    mem[16'h8000] = 16'h1111;
    mem[16'h8001] = 16'h2222;
    mem[16'h8002] = 16'h3333;

    repeat (3) @(negedge clk);
    check("reset dut1 outputs", {11'b0, observe(1'b1)}, 16'h0);
    check("reset dut1 memAddr", addr1, 16'h0000);
    check("reset dut0 outputs", {11'b0, observe(1'b0)}, 16'h0);
    check("reset dut0 memAddr", addr0, 16'h0000);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_op(1'b1, 16'h0010, 16'h0010, 16'h0100, 1'b0, 0,  "single");
    run_op(1'b1, 16'h8000, 16'h8002, 16'h1234, 1'b0, 0,  "three");
    run_op(1'b1, 16'hFFFF, 16'h0000, 16'hA5C3, 1'b0, 0,  "wrap");
    run_op(1'b1, 16'h8000, 16'h8002, 16'h0F0F, 1'b0, 40, "rstmid");
    repeat (2) @(negedge clk);
    run_op(1'b1, 16'h0010, 16'h0010, 16'h0100, 1'b0, 0,  "after_rst");
    run_op(1'b1, 16'h8000, 16'h8002, 16'h1234, 1'b1, 0,  "stray_start");
    run_op(1'b0, 16'h0010, 16'h0010, 16'h0100, 1'b0, 0,  "nowren");
    run_op(1'b0, 16'h8000, 16'h8002, 16'h4321, 1'b1, 0,  "nowren_three");

    for (int n = 0; n < 6; n++) begin
      rw = 1'($urandom);
      rf = 16'($urandom);
      rs = 16'($urandom);
      rn = $urandom_range(0, 4);
      if (n == 0) rf = 16'hFFFE;
      run_op(rw, rf, rf + 16'(rn), rs, 1'b0, 0, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_storage_writer
`default_nettype wire
